// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load-value clamp.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Non-decimal nibbles (10..15) are pulled down to 9 so no illegal digit is stored.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: clear > load > step > hold, wraps 9->0 going up and 0->9 going down.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Clear,
    input  logic       Load,
    input  bcd_digit_t LdDigit,
    input  logic       Step,
    input  logic       Up,
    output bcd_digit_t Digit,
    output logic       IsMax,
    output logic       IsMin
);

    bcd_digit_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (Clear) begin
            digit_d = BCD_MIN;
        end else if (Load) begin
            digit_d = bcd_clamp(LdDigit);
        end else if (Step) begin
            if (Up) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            else    digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) digit_q <= BCD_MIN;
        else         digit_q <= digit_d;
    end

    assign Digit = digit_q;
    assign IsMax = (digit_q == BCD_MAX);
    assign IsMin = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with cascade terminal count and registered wrap pulse.
// Build option: define BCD_SAT_EN to saturate at all-9 / all-0 instead of wrapping.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadVal,
    output logic [4*DIGITS-1:0]   Count,
    output logic                  Tc,
    output logic                  Wrapped
);

    logic [DIGITS-1:0] is_max, is_min, step;
    // max_chain[i] / min_chain[i]: every digit below i is at 9 / at 0.
    logic [DIGITS:0]   max_chain, min_chain;
    logic              terminal, en_step;
    logic              wrapped_q, wrapped_d;

    assign max_chain[0] = 1'b1;
    assign min_chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign max_chain[i+1] = max_chain[i] & is_max[i];
        assign min_chain[i+1] = min_chain[i] & is_min[i];
        assign step[i]        = en_step & (Up ? max_chain[i] : min_chain[i]);

        bcd_digit u_digit (
            .Clock   (Clock),
            .nReset  (nReset),
            .Clear   (Clear),
            .Load    (Load),
            .LdDigit (LoadVal[4*i +: 4]),
            .Step    (step[i]),
            .Up      (Up),
            .Digit   (Count[4*i +: 4]),
            .IsMax   (is_max[i]),
            .IsMin   (is_min[i])
        );
    end

    assign terminal = Up ? max_chain[DIGITS] : min_chain[DIGITS];

`ifdef BCD_SAT_EN
    // Stepping at the terminal value is suppressed, which holds the counter at its limit.
    assign en_step = Enable & ~terminal;
    assign Tc      = 1'b0;
`else
    assign en_step = Enable;
    assign Tc      = Enable & ~Clear & ~Load & terminal;
`endif

    // Tc already excludes Clear/Load, so a terminal step is exactly a wrap.
    assign wrapped_d = Tc;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) wrapped_q <= 1'b0;
        else         wrapped_q <= wrapped_d;
    end

    assign Wrapped = wrapped_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomised bench for bcd_updown_counter against an integer-arithmetic reference model.
module tb_bcd_updown_counter;

    localparam int D    = 3;
    localparam int MODV = 1000;
    localparam int MAXV = MODV - 1;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic          Enable = 1'b0;
    logic          Up = 1'b1;
    logic          Clear = 1'b0;
    logic          Load = 1'b0;
    logic [4*D-1:0] LoadVal = '0;
    logic [4*D-1:0] Count;
    logic          Tc;
    logic          Wrapped;

    int vecs = 0;
    int errs = 0;
    int m_cnt = 0;
    logic m_wrap = 1'b0;

    bcd_updown_counter #(.DIGITS(D)) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Enable  (Enable),
        .Up      (Up),
        .Clear   (Clear),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Count   (Count),
        .Tc      (Tc),
        .Wrapped (Wrapped)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int load_val(input logic [4*D-1:0] lv);
        int v, w, dg;
        v = 0;
        w = 1;
        for (int i = 0; i < D; i++) begin
            dg = int'(lv[4*i +: 4]);
            if (dg > 9) dg = 9;
            v += dg * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic model_tc();
        logic term;
        term = Up ? (m_cnt == MAXV) : (m_cnt == 0);
`ifdef BCD_SAT_EN
        return 1'b0 & term;
`else
        return Enable & ~Clear & ~Load & term;
`endif
    endfunction

    // Drive one cycle of inputs after a falling edge, check Tc, then check state after the rising edge.
    task automatic cyc(input logic en, input logic up, input logic clr, input logic ld,
                       input logic [4*D-1:0] lv);
        logic tc_e;
        @(negedge Clock);
        Enable = en; Up = up; Clear = clr; Load = ld; LoadVal = lv;
        #1;
        tc_e = model_tc();
        chk("tc", {31'd0, Tc}, {31'd0, tc_e});
        @(posedge Clock);
        m_wrap = tc_e;
        if (clr)      m_cnt = 0;
        else if (ld)  m_cnt = load_val(lv);
        else if (en) begin
`ifdef BCD_SAT_EN
            if (up) m_cnt = (m_cnt == MAXV) ? MAXV : m_cnt + 1;
            else    m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
`else
            if (up) m_cnt = (m_cnt + 1) % MODV;
            else    m_cnt = (m_cnt + MAXV) % MODV;
`endif
        end
        #1;
        chk("count", 32'(Count), 32'(to_bcd(m_cnt)));
        chk("wrapped", {31'd0, Wrapped}, {31'd0, m_wrap});
    endtask

    initial begin
        logic [4*D-1:0] lv;
        int sel;

        #2;
        chk("rst_count", 32'(Count), 32'h0);
        chk("rst_wrapped", {31'd0, Wrapped}, 32'h0);
        @(negedge Clock);
        nReset = 1'b1;

        // Up wrap from 998
        cyc(0, 1, 0, 1, 12'h998);
        repeat (3) cyc(1, 1, 0, 0, '0);
`ifdef BCD_SAT_EN
        chk("sat_hi", 32'(Count), 32'h999);
`else
        chk("upwrap_tail", 32'(Count), 32'h001);
`endif
        // Down wrap from 001
        cyc(0, 0, 0, 1, 12'h001);
        repeat (3) cyc(1, 0, 0, 0, '0);
        // Direction change across a digit ripple
        cyc(0, 1, 0, 1, 12'h099);
        cyc(1, 1, 0, 0, '0);
        chk("ripple_up", 32'(Count), 32'h100);
        cyc(1, 0, 0, 0, '0);
        chk("ripple_dn", 32'(Count), 32'h099);
        cyc(1, 0, 0, 0, '0);
        // Priority and clamp
        cyc(1, 1, 1, 1, 12'h123);
        chk("clr_prio", 32'(Count), 32'h000);
        cyc(1, 1, 0, 1, 12'hF5A);
        chk("clamp", 32'(Count), 32'h959);
        // Saturation / wrap at the top with enable held
        cyc(0, 1, 0, 1, 12'h998);
        repeat (4) cyc(1, 1, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        // Hold with enable low
        cyc(0, 1, 0, 0, '0);

        // Async reset mid-count at 457
        cyc(0, 1, 0, 1, 12'h457);
        cyc(1, 1, 0, 0, '0);
        @(negedge Clock);
        #2;
        nReset = 1'b0;
        #1;
        m_cnt = 0;
        m_wrap = 1'b0;
        chk("midrst_count", 32'(Count), 32'h0);
        chk("midrst_wrapped", {31'd0, Wrapped}, 32'h0);
        chk("midrst_tc", {31'd0, Tc}, 32'h0);
        @(negedge Clock);
        nReset = 1'b1;

        // Random traffic, loads biased toward the wrap boundaries
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       lv = 12'h999;
                1:       lv = 12'h000;
                default: lv = 12'($urandom);
            endcase
            cyc(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) == 0), lv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
